// File: rtl/mem_rw_if.sv
// Request/response bundle for mem_rw_ctrl: valid/ready request channel carrying
// read/write commands, and valid/ready response channel carrying results.
interface mem_rw_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_wr;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_wr, rsp_err
  );
endinterface

// File: rtl/mem_rw_ctrl.sv
// Single-port byte-enable memory behind a valid/ready request channel, with a
// 2-entry response FIFO so a stalled consumer never loses responses.
module mem_rw_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic     clk,
  input logic     rst_n,
  mem_rw_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] q_rdata_p0 [2];
  logic              q_wr_p0    [2];
  logic              q_err_p0   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;

  logic push;
  logic pop;
  logic in_range;

  // Response payload: only in-range reads carry memory data.
  function automatic logic [DATA_W-1:0] rsp_word(
    input logic              rw,
    input logic              ok,
    input logic [DATA_W-1:0] rd
  );
    return (!rw && ok) ? rd : '0;
  endfunction

  assign in_range = ({1'b0, bus.req_addr} < DEPTH_L);
  assign push     = bus.req_valid && bus.req_ready;
  assign pop      = bus.rsp_valid && bus.rsp_ready;

  assign bus.req_ready = (cnt != 2'd2);
  assign bus.rsp_valid = (cnt != 2'd0);
  assign bus.rsp_rdata = bus.rsp_valid ? q_rdata_p0[rd_ptr] : '0;
  assign bus.rsp_wr    = bus.rsp_valid ? q_wr_p0[rd_ptr]    : 1'b0;
  assign bus.rsp_err   = bus.rsp_valid ? q_err_p0[rd_ptr]   : 1'b0;

  // Stage p0: memory write at the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (push && bus.req_rw && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) mem[bus.req_addr][i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
      end
    end
  end

  // Stage p0: response capture; read data is taken before any later write.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rdata_p0[wr_ptr] <= rsp_word(bus.req_rw, in_range, mem[bus.req_addr]);
      q_wr_p0[wr_ptr]    <= bus.req_rw;
      q_err_p0[wr_ptr]   <= !in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rw_ctrl.sv
// Bench for mem_rw_ctrl (32-bit data, 12 words): queue-based reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_mem_rw_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DP = 12;

  logic clk = 1'b0;
  logic rst_n;

  mem_rw_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

  mem_rw_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array with per-byte known flags and a response queue.
  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    bit          wr;
    bit          err;
  } rsp_t;

  rsp_t     q[$];
  bit [31:0] mmem   [16];
  bit [3:0]  mknown [16];
  int cyc = 0;
  int pops = 0;
  int stalls = 0;
  int last_pop_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit   acc;
      bit   pp;
      rsp_t e;
      int   a;
      cyc++;
      acc = ifc.req_valid && (q.size() < 2);
      pp  = (q.size() != 0) && ifc.rsp_ready;
      if (ifc.req_valid && q.size() >= 2) stalls++;
      if (pp) begin
        void'(q.pop_front());
        pops++;
        last_pop_cyc = cyc;
      end
      if (acc) begin
        a       = int'(ifc.req_addr);
        e.wr    = ifc.req_rw;
        e.err   = (a >= DP);
        e.rdata = 32'h0;
        e.mask  = 32'hFFFF_FFFF;
        if (!e.err) begin
          if (ifc.req_rw) begin
            for (int i = 0; i < 4; i++) begin
              if (ifc.req_be[i]) begin
                mmem[a][i*8 +: 8] = ifc.req_wdata[i*8 +: 8];
                mknown[a][i] = 1'b1;
              end
            end
          end else begin
            e.rdata = mmem[a];
            for (int i = 0; i < 4; i++) e.mask[i*8 +: 8] = {8{mknown[a][i]}};
          end
        end
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("req_ready", ifc.req_ready, q.size() < 2);
      chk("rsp_valid", ifc.rsp_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rsp_wr", ifc.rsp_wr, q[0].wr);
        chk("rsp_err", ifc.rsp_err, q[0].err);
        chk("rsp_rdata", ifc.rsp_rdata & q[0].mask, q[0].rdata & q[0].mask);
      end
    end
  end

  task automatic set_req(input bit rw, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    ifc.req_valid = 1'b1;
    ifc.req_rw    = rw;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
    ifc.req_be    = be;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (ifc.req_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=req_ready_low required=accept t=%0t", $time);
    end
  endtask

  task automatic send(input bit rw, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    set_req(rw, a, d, be);
    wait_accept();
  endtask

  task automatic idle();
    ifc.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 t=%0t", q.size(), $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc;
    int stalls0;
    int pops0;
    rst_n = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_rw    = 1'b0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.req_be    = '0;
    ifc.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", ifc.req_ready, 1);
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_rsp_rdata", ifc.rsp_rdata, 0);
    chk("rst_rsp_wr", ifc.rsp_wr, 0);
    chk("rst_rsp_err", ifc.rsp_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic write/read with one-cycle latency
    ifc.rsp_ready = 1'b1;
    send(1'b1, 4'hA, 32'h0, 4'hF);
    send(1'b1, 4'hA, 32'h2F, 4'h1);
    chk("lat_wr_valid", ifc.rsp_valid, 1);
    chk("lat_wr_wr", ifc.rsp_wr, 1);
    chk("lat_wr_rdata", ifc.rsp_rdata, 0);
    send(1'b0, 4'hA, 32'hFFFF_FFFF, 4'hF);
    chk("lat_rd_valid", ifc.rsp_valid, 1);
    chk("lat_rd_wr", ifc.rsp_wr, 0);
    chk("lat_rd_rdata", ifc.rsp_rdata, 32'h2F);

    // Byte-merge and back-to-back read-after-write
    send(1'b1, 4'h3, 32'h1122_3344, 4'hF);
    send(1'b1, 4'h3, 32'hAABB_CCDD, 4'h5);
    send(1'b0, 4'h3, 32'h0, 4'h0);
    chk("merge_rdata", ifc.rsp_rdata, 32'h11BB_33DD);
    idle();
    drain();

    // Backpressure: third request held off until the first pop
    ifc.rsp_ready = 1'b0;
    send(1'b0, 4'h3, 32'h0, 4'h0);
    send(1'b0, 4'hA, 32'h0, 4'h0);
    chk("bp_ready_low", ifc.req_ready, 0);
    set_req(1'b0, 4'h3, 32'h0, 4'h0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", ifc.req_ready, 0);
      chk("bp_head_stable", ifc.rsp_rdata, 32'h11BB_33DD);
    end
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b1;
    wait_accept();
    idle();
    drain();

    // Out-of-range accesses leave memory untouched
    send(1'b1, 4'd11, 32'hCAFE_F00D, 4'hF);
    send(1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF);
    chk("oor_wr_err", ifc.rsp_err, 1);
    chk("oor_wr_wr", ifc.rsp_wr, 1);
    chk("oor_wr_rdata", ifc.rsp_rdata, 0);
    send(1'b0, 4'd13, 32'h0, 4'h0);
    chk("oor_rd_err", ifc.rsp_err, 1);
    chk("oor_rd_wr", ifc.rsp_wr, 0);
    chk("oor_rd_rdata", ifc.rsp_rdata, 0);
    send(1'b0, 4'd11, 32'h0, 4'h0);
    chk("prior_rdata", ifc.rsp_rdata, 32'hCAFE_F00D);
    chk("prior_err", ifc.rsp_err, 0);
    idle();
    drain();

    // Streaming: 16 writes then 16 reads, no bubbles
    start_cyc = cyc;
    stalls0   = stalls;
    pops0     = pops;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 32'h0101_0101 * i, 4'hF);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 32'h0, 4'h0);
    idle();
    drain();
    chk("stream_pops", pops - pops0, 32);
    chk("stream_cycles", last_pop_cyc - start_cyc, 33);
    chk("stream_stalls", stalls - stalls0, 0);

    // Reset with a full queue, memory persists
    ifc.rsp_ready = 1'b0;
    send(1'b0, 4'h3, 32'h0, 4'h0);
    send(1'b0, 4'h5, 32'h0, 4'h0);
    chk("full_ready", ifc.req_ready, 0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", ifc.rsp_valid, 0);
    chk("midrst_req_ready", ifc.req_ready, 1);
    chk("midrst_rsp_rdata", ifc.rsp_rdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ifc.rsp_ready = 1'b1;
    send(1'b0, 4'h5, 32'h0, 4'h0);
    chk("persist_valid", ifc.rsp_valid, 1);
    chk("persist_rdata", ifc.rsp_rdata, 32'h0505_0505);
    idle();
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rw_ctrl.md
# mem_rw_ctrl

Parametrised single-port memory with valid/ready request and response channels, byte-enable writes, out-of-range detection and a 2-entry response queue providing backpressure. It is the next-generation storage DUT driven through the `intf`-style testbench interface. It replaces the fixed 16x8 rw/addr memory with a handshaked block that tolerates a stalled consumer without losing responses.

## Interface
- `DATA_W`, 8, data width in bits; multiple of 8.
- `ADDR_W`, 4, address width.
- `DEPTH`, 16, number of words; 1 <= DEPTH <= 2**ADDR_W.
- `BE_W`, DATA_W/8, derived local parameter; byte-enable width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_rw`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `req_be`  in  BE_W  byte enables; write only.
- `rsp_valid`  out  1  response present at queue head.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and errors.
- `rsp_wr`  out  1  response belongs to a write.
- `rsp_err`  out  1  address >= DEPTH.

## Operation
- Request accepted when `req_valid && req_ready`. Every accepted request, read or write, produces exactly one response, in request order.
- Write accepted with in-range address: for each i with `req_be[i]=1`, byte i of `mem[req_addr]` is updated at the accepting edge. Bytes with `req_be[i]=0` are unchanged. Response: wr=1, err=0, rdata=0.
- Read accepted with in-range address: `mem[req_addr]` is captured at the accepting edge. Response: wr=0, err=0. `req_be` is ignored.
- Address >= DEPTH: no memory change. Response err=1, rdata=0, wr=req_rw.
- Response queue: 2 entries, FIFO, with occupancy counter `cnt` in 0..2.
  - `req_ready = (cnt < 2)`. This is a pure function of registered state, with no combinational path from `rsp_ready` or `req_valid`.
  - `rsp_valid = (cnt != 0)`. Head entry drives `rsp_rdata/rsp_wr/rsp_err`.
  - Pop when `rsp_valid && rsp_ready`.
  - Push and pop in the same cycle leaves `cnt` unchanged and keeps ordering.
- Head outputs are held stable while `rsp_valid && !rsp_ready`.
- Reset (async assert, any time): `cnt`=0 and queue pointers = 0.
  - Outputs: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_wr`=0, `rsp_err`=0.
  - In-flight responses are discarded. Memory array is NOT reset; contents persist across reset and are undefined at power-up.
- Reset deassertion is assumed synchronised externally. The first acceptance can occur on the first rising edge after `rst_n` goes high.

## Timing
- Latency: request accepted at edge N gives `rsp_valid`=1 in the cycle after edge N, when the queue was empty.
- Throughput: 1 request/cycle sustained while `rsp_ready`=1 (cnt stays <= 1).
- With `rsp_ready`=0: at most 2 requests are accepted. `req_ready` drops in the cycle after the second acceptance.
  - It rises again in the cycle after the first pop.
- Read-after-write, same address, back-to-back: the read accepted at edge N+1 returns the data written at edge N (byte-merged).
- A write never affects the data of a read response already queued.

## Test plan
- Reset, then write addr 0xA data 0x2F be=1, then read 0xA, `rsp_ready`=1 -> responses (wr=1, err=0, rdata=0), then (wr=0, rdata=0x2F), each 1 cycle after acceptance.
- DATA_W=32: write 0x11223344 be=0xF to addr 3, then write 0xAABBCCDD be=0x5, then read addr 3 -> rdata=0x11BB33DD.
- `rsp_ready`=0, issue 3 back-to-back reads -> 2 accepted, `req_ready`=0 from the next cycle. Raise `rsp_ready` -> all 3 responses delivered in order, with head held stable while stalled.
- DEPTH=12, ADDR_W=4: write addr 13, then read addr 13 -> both err=1 and rdata=0. Read addr 11 returns its prior contents unchanged.
- Streaming 16 writes then 16 reads with `rsp_ready`=1 -> 32 responses in 33 cycles, with no bubbles on `req_ready`.
- Assert `rst_n`=0 with cnt=2 mid-stream, then release and read a previously written address -> `rsp_valid`=0 immediately at reset assertion, `req_ready`=1. The stale responses are never seen, and the memory data survives reset.
